// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: data-cache handshake, byte masks, store lane replication and load extension.
// Optional performance counters are enabled by defining LSU_PERF_CNT_EN.
module mem_stage_lsu #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_read_i,
  input  logic                  mem_write_i,
  input  logic [2:0]            funct3_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [31:0]           store_data_i,
  input  logic                  advance_i,
  output logic [ADDR_WIDTH-1:0] dmem_address,
  output logic                  dmem_read,
  output logic                  dmem_write,
  output logic [3:0]            dmem_mbe,
  output logic [31:0]           dmem_wdata,
  input  logic [31:0]           dmem_rdata,
  input  logic                  dmem_resp,
  output logic                  stall_o,
  output logic [3:0]            wmask_o,
  output logic [31:0]           load_data_o,
  output logic                  err_o
`ifdef LSU_PERF_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0]  ld_cnt_o,
  output logic [CNT_WIDTH-1:0]  st_cnt_o,
  output logic [CNT_WIDTH-1:0]  stall_cnt_o
`endif
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]            state, state_nxt;
  logic                  req, err, misalign, bad_code;
  logic [3:0]            mask;
  logic [31:0]           wdata;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [3:0]            mask_q;
  logic [31:0]           wdata_q, rdata_q, ext;
  logic [2:0]            f3_q;
  logic                  write_q;
  logic [1:0]            off_q;
  logic [7:0]            byte_sel;
  logic [15:0]           half_sel;
  logic                  idle, busy, done;

  assign req  = mem_read_i | mem_write_i;
  assign idle = (state == IDLE);
  assign busy = (state == BUSY);
  assign done = (state == DONE);

  always_comb begin
    mask     = '0;
    wdata    = '0;
    misalign = 1'b0;
    case (funct3_i[1:0])
      2'b00: begin
        mask  = 4'b0001 << addr_i[1:0];
        wdata = {4{store_data_i[7:0]}};
      end
      2'b01: begin
        mask     = 4'b0011 << {addr_i[1], 1'b0};
        wdata    = {2{store_data_i[15:0]}};
        misalign = addr_i[0];
      end
      2'b10: begin
        mask     = 4'b1111;
        wdata    = store_data_i;
        misalign = |addr_i[1:0];
      end
      default: ;
    endcase
  end

  // Stores accept only 000/001/010; loads additionally accept the unsigned 100/101.
  assign bad_code = mem_write_i ? (funct3_i[2] | (funct3_i[1:0] == 2'b11))
                                : ((funct3_i[1:0] == 2'b11) | (funct3_i[2] & funct3_i[1]));
  assign err = req & ((mem_read_i & mem_write_i) | misalign | bad_code);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req && !err) state_nxt = BUSY;
      BUSY:    if (dmem_resp)   state_nxt = DONE;
      DONE:    if (advance_i)   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      addr_q  <= '0;
      mask_q  <= '0;
      wdata_q <= '0;
      f3_q    <= '0;
      write_q <= 1'b0;
      off_q   <= '0;
      rdata_q <= '0;
    end else begin
      state <= state_nxt;
      if (idle && req && !err) begin
        addr_q  <= {addr_i[ADDR_WIDTH-1:2], 2'b00};
        mask_q  <= mask;
        wdata_q <= mem_write_i ? wdata : '0;
        f3_q    <= funct3_i;
        write_q <= mem_write_i;
        off_q   <= addr_i[1:0];
        rdata_q <= '0;
      end
      if (busy && dmem_resp && !write_q) rdata_q <= dmem_rdata;
    end
  end

  always_comb begin
    case (off_q)
      2'd0:    byte_sel = rdata_q[7:0];
      2'd1:    byte_sel = rdata_q[15:8];
      2'd2:    byte_sel = rdata_q[23:16];
      default: byte_sel = rdata_q[31:24];
    endcase
    half_sel = off_q[1] ? rdata_q[31:16] : rdata_q[15:0];
    case (f3_q)
      3'b000:  ext = {{24{byte_sel[7]}}, byte_sel};
      3'b100:  ext = {24'd0, byte_sel};
      3'b001:  ext = {{16{half_sel[15]}}, half_sel};
      3'b101:  ext = {16'd0, half_sel};
      default: ext = rdata_q;
    endcase
  end

  // Input-derived outputs are gated by rst so everything reads zero while reset is held.
  assign dmem_address = busy ? addr_q : '0;
  assign dmem_read    = busy & ~write_q;
  assign dmem_write   = busy & write_q;
  assign dmem_mbe     = busy ? mask_q : '0;
  assign dmem_wdata   = busy ? wdata_q : '0;
  assign stall_o      = busy | (rst & idle & req & ~err);
  assign wmask_o      = idle ? ((rst & req & ~err) ? mask : '0) : mask_q;
  assign load_data_o  = done ? ext : '0;
  assign err_o        = rst & idle & err;

`ifdef LSU_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ld_cnt_o    <= '0;
      st_cnt_o    <= '0;
      stall_cnt_o <= '0;
    end else begin
      if (busy && dmem_resp && !write_q) ld_cnt_o <= ld_cnt_o + 1'b1;
      if (busy && dmem_resp && write_q)  st_cnt_o <= st_cnt_o + 1'b1;
      if (stall_o)                       stall_cnt_o <= stall_cnt_o + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Bench for mem_stage_lsu: directed vector table, hand-written reset/hold sequences, randomized traffic vs. a reference model.
module tb_mem_stage_lsu;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_read_i = 1'b0, mem_write_i = 1'b0, advance_i = 1'b0;
  logic [2:0]  funct3_i = '0;
  logic [31:0] addr_i = '0, store_data_i = '0;
  logic [31:0] dmem_address, dmem_wdata, load_data_o;
  logic [31:0] dmem_rdata = '0;
  logic        dmem_read, dmem_write, dmem_resp = 1'b0, stall_o, err_o;
  logic [3:0]  dmem_mbe, wmask_o;
`ifdef LSU_PERF_CNT_EN
  logic [31:0] ld_cnt, st_cnt, stall_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int exp_ld = 0;
  int exp_st = 0;

  always #5 clk = ~clk;

  mem_stage_lsu #(.ADDR_WIDTH(32), .CNT_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .mem_read_i(mem_read_i), .mem_write_i(mem_write_i), .funct3_i(funct3_i),
    .addr_i(addr_i), .store_data_i(store_data_i), .advance_i(advance_i),
    .dmem_address(dmem_address), .dmem_read(dmem_read), .dmem_write(dmem_write),
    .dmem_mbe(dmem_mbe), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
    .dmem_resp(dmem_resp), .stall_o(stall_o), .wmask_o(wmask_o),
    .load_data_o(load_data_o), .err_o(err_o)
`ifdef LSU_PERF_CNT_EN
    , .ld_cnt_o(ld_cnt), .st_cnt_o(st_cnt), .stall_cnt_o(stall_cnt)
`endif
  );

  typedef struct {
    bit          rd;
    bit          wr;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] sd;
    logic [31:0] rdata;
    int          lat;
    int          hold;
    logic [3:0]  mask;
    logic [31:0] wdata;
    logic [31:0] load;
    bit          err;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: access size in bytes is 1 << funct3[1:0].
  function automatic bit m_err(bit rd, bit wr, logic [2:0] f3, logic [31:0] a);
    int n;
    if (!(rd || wr)) return 1'b0;
    if (rd && wr) return 1'b1;
    if (f3[1:0] == 2'b11) return 1'b1;
    if (wr && int'(f3) > 2) return 1'b1;
    if (rd && int'(f3) > 5) return 1'b1;
    n = 1 << int'(f3[1:0]);
    return (int'(a[1:0]) % n) != 0;
  endfunction

  function automatic logic [3:0] m_mask(logic [2:0] f3, logic [31:0] a);
    int n = 1 << int'(f3[1:0]);
    int m = ((1 << n) - 1) << int'(a[1:0]);
    return 4'(m);
  endfunction

  function automatic logic [31:0] m_wdata(logic [2:0] f3, logic [31:0] sd);
    int n = 1 << int'(f3[1:0]);
    logic [31:0] w;
    for (int k = 0; k < 4; k++) w[8*k +: 8] = sd[8*(k % n) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] m_load(logic [2:0] f3, logic [31:0] a, logic [31:0] rdata);
    int n = 1 << int'(f3[1:0]);
    longint v = (longint'(rdata) >> (8 * int'(a[1:0]))) & ((64'sd1 <<< (8 * n)) - 1);
    if (!f3[2] && n < 4 && (((v >> (8 * n - 1)) & 1) == 1)) v = v - (64'sd1 <<< (8 * n));
    return 32'(v);
  endfunction

  task automatic txn(input vec_t v);
    @(negedge clk);
    mem_read_i = v.rd; mem_write_i = v.wr; funct3_i = v.f3; addr_i = v.a;
    store_data_i = v.sd; dmem_resp = 1'b0; advance_i = 1'b0;
    #1;
    chk("req_err", 32'(err_o), 32'(v.err));
    if (v.err) begin
      chk("err_stall", 32'(stall_o), 32'd0);
      chk("err_load", load_data_o, 32'd0);
      chk("err_access", 32'({dmem_read, dmem_write}), 32'd0);
      @(negedge clk);
      mem_read_i = 1'b0; mem_write_i = 1'b0;
      #1;
      chk("err_no_issue", 32'({dmem_read, dmem_write, stall_o}), 32'd0);
      return;
    end
    chk("req_stall", 32'(stall_o), 32'd1);
    chk("req_wmask", 32'(wmask_o), 32'(v.mask));
    chk("req_no_access_yet", 32'({dmem_read, dmem_write}), 32'd0);
    for (int i = 0; i < v.lat; i++) begin
      @(negedge clk);
      mem_read_i = 1'($urandom); mem_write_i = 1'($urandom); funct3_i = 3'($urandom);
      addr_i = $urandom; store_data_i = $urandom; advance_i = 1'($urandom);
      dmem_resp = (i == v.lat - 1);
      dmem_rdata = (i == v.lat - 1) ? v.rdata : $urandom;
      #1;
      chk("busy_read", 32'(dmem_read), 32'(v.rd));
      chk("busy_write", 32'(dmem_write), 32'(v.wr));
      chk("busy_addr", dmem_address, {v.a[31:2], 2'b00});
      chk("busy_mbe", 32'(dmem_mbe), 32'(v.mask));
      chk("busy_wdata", dmem_wdata, v.wdata);
      chk("busy_stall", 32'(stall_o), 32'd1);
      chk("busy_wmask", 32'(wmask_o), 32'(v.mask));
    end
    mem_read_i = v.rd; mem_write_i = v.wr; funct3_i = v.f3; addr_i = v.a; store_data_i = v.sd;
    if (v.wr) exp_st++; else exp_ld++;
    for (int h = 0; h <= v.hold; h++) begin
      @(negedge clk);
      advance_i = (h == v.hold);
      dmem_resp = (h == 1);
      dmem_rdata = $urandom;
      #1;
      chk("done_stall", 32'(stall_o), 32'd0);
      chk("done_load", load_data_o, v.load);
      chk("done_no_reissue", 32'({dmem_read, dmem_write}), 32'd0);
      chk("done_wmask", 32'(wmask_o), 32'(v.mask));
`ifdef LSU_PERF_CNT_EN
      chk("ld_cnt", ld_cnt, 32'(exp_ld));
      chk("st_cnt", st_cnt, 32'(exp_st));
`endif
    end
    @(negedge clk);
    mem_read_i = 1'b0; mem_write_i = 1'b0; advance_i = 1'b0; dmem_resp = 1'b0;
    #1;
    chk("idle_stall", 32'(stall_o), 32'd0);
    chk("idle_load", load_data_o, 32'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ctl"}, 32'({stall_o, err_o, dmem_read, dmem_write, wmask_o, dmem_mbe}), 32'd0);
    chk({tag, "_addr"}, dmem_address, 32'd0);
    chk({tag, "_wdata"}, dmem_wdata, 32'd0);
    chk({tag, "_load"}, load_data_o, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t v;
    tbl.push_back('{1'b0, 1'b1, 3'b010, 32'h100,  32'hDEADBEEF, 32'h0,        3, 0, 4'hF, 32'hDEADBEEF, 32'h0,        1'b0});
    tbl.push_back('{1'b0, 1'b1, 3'b000, 32'h103,  32'h000000A5, 32'h0,        1, 0, 4'h8, 32'hA5A5A5A5, 32'h0,        1'b0});
    tbl.push_back('{1'b1, 1'b0, 3'b000, 32'h202,  32'hFFFFFFFF, 32'h80F08001, 1, 0, 4'h4, 32'h0,        32'hFFFFFFF0, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 3'b100, 32'h202,  32'hFFFFFFFF, 32'h80F08001, 2, 0, 4'h4, 32'h0,        32'h000000F0, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 3'b001, 32'h202,  32'hFFFFFFFF, 32'h80F08001, 1, 1, 4'hC, 32'h0,        32'hFFFF80F0, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 3'b101, 32'h202,  32'hFFFFFFFF, 32'h80F08001, 3, 0, 4'hC, 32'h0,        32'h000080F0, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 3'b010, 32'h101,  32'h0,        32'h0,        1, 0, 4'h0, 32'h0,        32'h0,        1'b1});
    tbl.push_back('{1'b1, 1'b0, 3'b011, 32'h100,  32'h0,        32'h0,        1, 0, 4'h0, 32'h0,        32'h0,        1'b1});
    tbl.push_back('{1'b0, 1'b1, 3'b001, 32'h102,  32'h1234ABCD, 32'h0,        2, 0, 4'hC, 32'hABCDABCD, 32'h0,        1'b0});
    tbl.push_back('{1'b1, 1'b0, 3'b010, 32'h300,  32'h0,        32'h12345678, 1, 0, 4'hF, 32'h0,        32'h12345678, 1'b0});
    tbl.push_back('{1'b1, 1'b1, 3'b010, 32'h100,  32'h0,        32'h0,        1, 0, 4'h0, 32'h0,        32'h0,        1'b1});
    tbl.push_back('{1'b1, 1'b0, 3'b001, 32'h203,  32'h0,        32'h0,        1, 0, 4'h0, 32'h0,        32'h0,        1'b1});
    tbl.push_back('{1'b0, 1'b1, 3'b100, 32'h100,  32'h0,        32'h0,        1, 0, 4'h0, 32'h0,        32'h0,        1'b1});
    tbl.push_back('{1'b1, 1'b0, 3'b010, 32'h500,  32'h0,        32'hCAFEF00D, 2, 5, 4'hF, 32'h0,        32'hCAFEF00D, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 3'b000, 32'h1001, 32'h0,        32'h00007F00, 1, 0, 4'h2, 32'h0,        32'h0000007F, 1'b0});

    repeat (2) @(negedge clk);
    #1;
    chk_all_zero("reset");
    rst = 1'b1;

    foreach (tbl[i]) txn(tbl[i]);

    // Reset while an access is outstanding, then a late response must be ignored.
    @(negedge clk);
    mem_read_i = 1'b1; funct3_i = 3'b010; addr_i = 32'h400;
    @(negedge clk);
    mem_read_i = 1'b0;
    #1;
    chk("rst_busy_read", 32'(dmem_read), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_all_zero("rst_mid_busy");
    exp_ld = 0; exp_st = 0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    dmem_resp = 1'b1; dmem_rdata = 32'h55AA55AA;
    #1;
    chk_all_zero("late_resp");
    @(negedge clk);
    dmem_resp = 1'b0;
    #1;
    chk_all_zero("after_late_resp");

    for (int n = 0; n < 150; n++) begin
      logic [1:0] dir;
      dir = 2'($urandom_range(1, 3));
      v.rd = dir[0]; v.wr = dir[1];
      v.f3 = 3'($urandom); v.a = $urandom; v.sd = $urandom; v.rdata = $urandom;
      v.lat = $urandom_range(1, 4); v.hold = $urandom_range(0, 2);
      v.err = m_err(v.rd, v.wr, v.f3, v.a);
      v.mask = v.err ? 4'h0 : m_mask(v.f3, v.a);
      v.wdata = (v.wr && !v.err) ? m_wdata(v.f3, v.sd) : 32'h0;
      v.load = (v.wr || v.err) ? 32'h0 : m_load(v.f3, v.a, v.rdata);
      txn(v);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
